// File: rtl/sat_bin_pkg.sv
// Shared types and default widths for the sat_bin unload engine.
// Module parameters default to these values, so WIDTH_OUT matches the default build.
package sat_bin_pkg;

  localparam int unsigned DEF_NUM_CLAUSES_A_BIN = 8;
  localparam int unsigned DEF_NUM_VARS_A_BIN    = 8;
  localparam int unsigned DEF_WIDTH_BIN_ID      = 10;
  localparam int unsigned DEF_WIDTH_CLAUSES     = 16;
  localparam int unsigned DEF_WIDTH_VAR         = 12;
  localparam int unsigned DEF_WIDTH_VAR_STATES  = 19;
  localparam int unsigned DEF_WIDTH_LVL_STATES  = 11;
  localparam int unsigned DEF_ADDR_WIDTH        = 9;

  localparam int unsigned WIDTH_OUT =
    DEF_WIDTH_VAR + DEF_WIDTH_VAR_STATES + DEF_WIDTH_LVL_STATES;

  typedef enum logic {
    KIND_CLAUSE = 1'b0,
    KIND_VAR    = 1'b1
  } kind_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_C  = 3'd1,
    ST_RD_V  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/sb_unload_buf.sv
// Two-entry beat FIFO {last, kind, addr, data} with valid/ready on both sides.
// An empty FIFO passes the incoming beat straight through so a read shows up one cycle after issue.
module sb_unload_buf
  import sat_bin_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = WIDTH_OUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  input  kind_e                 in_kind_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output kind_e                 out_kind_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic [1:0]            count_o
);

  localparam int unsigned EW = 2 + ADDR_WIDTH + DATA_WIDTH;

  logic [EW-1:0] mem_q [2];
  logic [EW-1:0] mem_d [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    count_q, count_d;

  logic [EW-1:0] in_entry;
  logic [EW-1:0] head;
  logic          empty;
  logic          push;
  logic          pop_mem;

  assign in_entry = {in_last_i, in_kind_i, in_addr_i, in_data_i};

  always_comb begin
    empty       = (count_q == 2'd0);
    out_valid_o = !empty || in_valid_i;
    head        = empty ? in_entry : mem_q[rd_ptr_q];
    if (!out_valid_o) begin
      head = '0;
    end
    // Bypass only when nothing is queued and the consumer takes it now.
    push    = in_valid_i && !(empty && out_ready_i);
    pop_mem = out_valid_o && out_ready_i && !empty;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_mem) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop_mem);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_last_o = head[EW-1];
  assign out_kind_o = kind_e'(head[EW-2]);
  assign out_addr_o = head[DATA_WIDTH +: ADDR_WIDTH];
  assign out_data_o = head[DATA_WIDTH-1:0];
  assign count_o    = count_q;

endmodule

// File: rtl/sat_bin_unload.sv
// Read-back engine: walks the clause BRAM then the var/var-state/lvl-state BRAMs at 1-based
// addresses and streams every entry out on a valid/ready port for the host collector.
module sat_bin_unload
  import sat_bin_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES_A_BIN = DEF_NUM_CLAUSES_A_BIN,
  parameter int unsigned NUM_VARS_A_BIN    = DEF_NUM_VARS_A_BIN,
  parameter int unsigned WIDTH_BIN_ID      = DEF_WIDTH_BIN_ID,
  parameter int unsigned WIDTH_CLAUSES     = DEF_WIDTH_CLAUSES,
  parameter int unsigned WIDTH_VAR         = DEF_WIDTH_VAR,
  parameter int unsigned WIDTH_VAR_STATES  = DEF_WIDTH_VAR_STATES,
  parameter int unsigned WIDTH_LVL_STATES  = DEF_WIDTH_LVL_STATES,
  parameter int unsigned ADDR_WIDTH        = DEF_ADDR_WIDTH
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               start_i,
  input  logic [WIDTH_BIN_ID-1:0]                            nb_i,
  output logic                                               busy_o,
  output logic                                               done_o,
  output logic                                               ovf_o,
  output logic                                               ram_en_c_o,
  output logic [ADDR_WIDTH-1:0]                              ram_addr_c_o,
  input  logic [WIDTH_CLAUSES-1:0]                           ram_dout_c_i,
  output logic                                               ram_en_v_o,
  output logic [ADDR_WIDTH-1:0]                              ram_addr_v_o,
  input  logic [WIDTH_VAR-1:0]                               ram_dout_v_i,
  input  logic [WIDTH_VAR_STATES-1:0]                        ram_dout_vs_i,
  input  logic [WIDTH_LVL_STATES-1:0]                        ram_dout_ls_i,
  output logic                                               out_valid_o,
  input  logic                                               out_ready_i,
  output logic                                               out_kind_o,
  output logic [ADDR_WIDTH-1:0]                              out_addr_o,
  output logic [WIDTH_VAR+WIDTH_VAR_STATES+WIDTH_LVL_STATES-1:0] out_data_o,
  output logic                                               out_last_o
);

  localparam int unsigned WOUT = WIDTH_VAR + WIDTH_VAR_STATES + WIDTH_LVL_STATES;
  localparam int unsigned CWC  = WIDTH_BIN_ID + $clog2(NUM_CLAUSES_A_BIN);
  localparam int unsigned CWV  = WIDTH_BIN_ID + $clog2(NUM_VARS_A_BIN);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   end_c_q, end_c_d;
  logic [ADDR_WIDTH-1:0]   end_v_q, end_v_d;
  logic                    ovf_q, ovf_d;
  logic                    rd_valid_q, rd_valid_d;
  kind_e                   rd_kind_q, rd_kind_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    rd_last_q, rd_last_d;

  logic [CWC-1:0]          nc_full;
  logic [CWV-1:0]          nv_full;
  logic                    nc_big, nv_big;
  logic                    can_issue;
  logic [WOUT-1:0]         rd_data;
  logic [1:0]              buf_count;
  logic                    buf_valid;
  logic                    buf_last;
  kind_e                   buf_kind;

  assign nc_full = CWC'(nb_i) * CWC'(NUM_CLAUSES_A_BIN);
  assign nv_full = CWV'(nb_i) * CWV'(NUM_VARS_A_BIN);
  assign nc_big  = nc_full > CWC'(ADDR_MAX);
  assign nv_big  = nv_full > CWV'(ADDR_MAX);

  // Queued beats plus the read still in the BRAM pipe must leave room for one more.
  assign can_issue = (buf_count + 2'(rd_valid_q)) < 2'd2;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    end_c_d      = end_c_q;
    end_v_d      = end_v_q;
    ovf_d        = ovf_q;
    rd_valid_d   = 1'b0;
    rd_kind_d    = rd_kind_q;
    rd_addr_d    = rd_addr_q;
    rd_last_d    = rd_last_q;
    ram_en_c_o   = 1'b0;
    ram_en_v_o   = 1'b0;
    ram_addr_c_o = '0;
    ram_addr_v_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          end_c_d = nc_big ? ADDR_MAX : nc_full[ADDR_WIDTH-1:0];
          end_v_d = nv_big ? ADDR_MAX : nv_full[ADDR_WIDTH-1:0];
          ovf_d   = nc_big || nv_big;
          addr_d  = ADDR_ONE;
          state_d = (nb_i == '0) ? ST_DONE : ST_RD_C;
        end
      end
      ST_RD_C: begin
        ram_addr_c_o = addr_q;
        if (can_issue) begin
          ram_en_c_o = 1'b1;
          rd_valid_d = 1'b1;
          rd_kind_d  = KIND_CLAUSE;
          rd_addr_d  = addr_q;
          rd_last_d  = 1'b0;
          if (addr_q == end_c_q) begin
            addr_d  = ADDR_ONE;
            state_d = ST_RD_V;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
      end
      ST_RD_V: begin
        ram_addr_v_o = addr_q;
        if (can_issue) begin
          ram_en_v_o = 1'b1;
          rd_valid_d = 1'b1;
          rd_kind_d  = KIND_VAR;
          rd_addr_d  = addr_q;
          rd_last_d  = (addr_q == end_v_q);
          if (addr_q == end_v_q) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
      end
      ST_DRAIN: begin
        // The last-flagged beat is the final one, so the buffer is empty once it transfers.
        if (buf_valid && out_ready_i && buf_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      end_c_q    <= '0;
      end_v_q    <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_kind_q  <= KIND_CLAUSE;
      rd_addr_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      end_c_q    <= end_c_d;
      end_v_q    <= end_v_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_kind_q  <= rd_kind_d;
      rd_addr_q  <= rd_addr_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign rd_data = (rd_kind_q == KIND_VAR) ? {ram_dout_v_i, ram_dout_vs_i, ram_dout_ls_i}
                                           : WOUT'(ram_dout_c_i);

  sb_unload_buf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(WOUT)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst),
    .in_valid_i (rd_valid_q),
    .in_kind_i  (rd_kind_q),
    .in_addr_i  (rd_addr_q),
    .in_data_i  (rd_data),
    .in_last_i  (rd_last_q),
    .out_valid_o(buf_valid),
    .out_ready_i(out_ready_i),
    .out_kind_o (buf_kind),
    .out_addr_o (out_addr_o),
    .out_data_o (out_data_o),
    .out_last_o (buf_last),
    .count_o    (buf_count)
  );

  assign out_valid_o = buf_valid;
  assign out_last_o  = buf_last;
  assign out_kind_o  = buf_kind;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_sat_bin_unload.sv
// Directed bench for sat_bin_unload: BRAM model with fixed address patterns, beat-by-beat checks.
module tb_sat_bin_unload;
  import sat_bin_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned WO = WIDTH_OUT;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic [9:0]    nb_i = '0;
  logic          busy_o, done_o, ovf_o;
  logic          ram_en_c_o, ram_en_v_o;
  logic [AW-1:0] ram_addr_c_o, ram_addr_v_o;
  logic [15:0]   dout_c = '0;
  logic [11:0]   dout_v = '0;
  logic [18:0]   dout_vs = '0;
  logic [10:0]   dout_ls = '0;
  logic          out_valid_o;
  logic          out_ready = 1'b1;
  logic          out_kind_o;
  logic [AW-1:0] out_addr_o;
  logic [WO-1:0] out_data_o;
  logic          out_last_o;

  int total = 0;
  int bad   = 0;

  sat_bin_unload dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .nb_i         (nb_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .ovf_o        (ovf_o),
    .ram_en_c_o   (ram_en_c_o),
    .ram_addr_c_o (ram_addr_c_o),
    .ram_dout_c_i (dout_c),
    .ram_en_v_o   (ram_en_v_o),
    .ram_addr_v_o (ram_addr_v_o),
    .ram_dout_v_i (dout_v),
    .ram_dout_vs_i(dout_vs),
    .ram_dout_ls_i(dout_ls),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready),
    .out_kind_o   (out_kind_o),
    .out_addr_o   (out_addr_o),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] clause_pat(input int unsigned a);
    return 16'((a * 263) ^ 32'h5A5A);
  endfunction
  function automatic logic [11:0] var_pat(input int unsigned a);
    return 12'(a ^ 32'hA50);
  endfunction
  function automatic logic [18:0] vs_pat(input int unsigned a);
    return 19'((a * 7) + 32'h12345);
  endfunction
  function automatic logic [10:0] ls_pat(input int unsigned a);
    return 11'(a ^ 32'h3C3);
  endfunction

  // Registered-read BRAM model, one cycle latency.
  always @(posedge clk) begin
    if (ram_en_c_o) dout_c <= clause_pat(32'(ram_addr_c_o));
    if (ram_en_v_o) begin
      dout_v  <= var_pat(32'(ram_addr_v_o));
      dout_vs <= vs_pat(32'(ram_addr_v_o));
      dout_ls <= ls_pat(32'(ram_addr_v_o));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input int unsigned b, input int unsigned nc);
    int unsigned a;
    if (b < nc) return 64'(clause_pat(b + 1));
    a = b - nc + 1;
    return 64'({var_pat(a), vs_pat(a), ls_pat(a)});
  endfunction

  // mode 0: ready high; 1: ready toggles; 2: ready high plus stray start pulses at beat 3 and in DONE.
  task automatic run_unload(input int unsigned nb, input int unsigned mode, input int exp_busy,
                            input logic exp_ovf, input string tag);
    int unsigned nc, nexp, beats, cyc, done_cnt, done_cyc, first_fire, last_fire;
    int          busy_cyc;
    logic        prev_hold, addr0_seen, act_seen, fire, rs_beat, rs_done;
    logic [WO-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    nc = nb * 8;
    if (nc > 511) nc = 511;
    nexp = 2 * nc;
    beats = 0; cyc = 0; done_cnt = 0; done_cyc = 0; first_fire = 0; last_fire = 0;
    busy_cyc = 0; prev_hold = 0; addr0_seen = 0; act_seen = 0; rs_beat = 0; rs_done = 0;
    prev_data = '0; prev_addr = '0;
    @(negedge clk);
    nb_i = 10'(nb);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (cyc < 3000 && !(done_cnt > 0 && cyc > done_cyc + 2)) begin
      out_ready = (mode == 1) ? cyc[0] : 1'b1;
      #1;
      if (busy_o) busy_cyc++;
      if ((ram_en_c_o && ram_addr_c_o == '0) || (ram_en_v_o && ram_addr_v_o == '0)) addr0_seen = 1;
      if (ram_en_c_o || ram_en_v_o || out_valid_o) act_seen = 1;
      if (cyc == 1 && nb > 0) check({tag, "_first_en"}, 64'(ram_en_c_o), 64'd1);
      if (cyc == 2 && nb > 0) check({tag, "_first_valid"}, 64'(out_valid_o), 64'd1);
      if (prev_hold) begin
        check({tag, "_hold_valid"}, 64'(out_valid_o), 64'd1);
        check({tag, "_hold_data"}, 64'(out_data_o), 64'(prev_data));
        check({tag, "_hold_addr"}, 64'(out_addr_o), 64'(prev_addr));
      end
      fire = out_valid_o && out_ready;
      if (fire) begin
        if (beats < nexp) begin
          check({tag, "_kind"}, 64'(out_kind_o), 64'(beats >= nc));
          check({tag, "_addr"}, 64'(out_addr_o), 64'((beats < nc) ? beats + 1 : beats - nc + 1));
          check({tag, "_data"}, 64'(out_data_o), exp_data(beats, nc));
          check({tag, "_last"}, 64'(out_last_o), 64'(beats == nexp - 1));
        end
        if (beats == 0) first_fire = cyc;
        last_fire = cyc;
        beats++;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_hold = out_valid_o && !out_ready;
      prev_data = out_data_o;
      prev_addr = out_addr_o;
      start_i = 1'b0;
      if (mode == 2 && beats == 3 && !rs_beat) begin
        start_i = 1'b1;
        nb_i    = 10'd5;
        rs_beat = 1;
      end
      if (mode == 2 && done_o && !rs_done) begin
        start_i = 1'b1;
        rs_done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    check({tag, "_beats"}, 64'(beats), 64'(nexp));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    if (nb > 0) begin
      check({tag, "_done_after_last"}, 64'(done_cyc), 64'(last_fire + 1));
    end else begin
      check({tag, "_done_cyc"}, 64'(done_cyc), 64'd1);
      check({tag, "_no_activity"}, 64'(act_seen), 64'd0);
    end
    if (mode != 1 && nb > 0) begin
      check({tag, "_first_fire"}, 64'(first_fire), 64'd2);
      check({tag, "_back_to_back"}, 64'(last_fire - first_fire + 1), 64'(nexp));
    end
    if (exp_busy >= 0) check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
    check({tag, "_addr0"}, 64'(addr0_seen), 64'd0);
    check({tag, "_ovf"}, 64'(ovf_o), 64'(exp_ovf));
    check({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    int unsigned pre_beats;
    int unsigned guard;
    #3;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_en_c", 64'(ram_en_c_o), 64'd0);
    check("rst_en_v", 64'(ram_en_v_o), 64'd0);
    check("rst_data", 64'(out_data_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_unload(1, 0, 18, 1'b0, "nb1");
    run_unload(2, 1, -1, 1'b0, "nb2_tog");
    run_unload(0, 0, 1, 1'b0, "nb0");
    run_unload(100, 0, -1, 1'b1, "nb100");
    run_unload(1, 0, 18, 1'b0, "ovf_clr");

    // Reset while beat 5 is on the output
    @(negedge clk);
    nb_i = 10'd1;
    start_i = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    pre_beats = 0;
    guard = 0;
    while (pre_beats < 4 && guard < 50) begin
      #1;
      if (out_valid_o && out_ready) pre_beats++;
      @(negedge clk);
      guard++;
    end
    check("mid_pre_beats", 64'(pre_beats), 64'd4);
    #1;
    check("mid_beat5_addr", 64'(out_addr_o), 64'd5);
    rst = 1'b0;
    #1;
    check("mid_valid", 64'(out_valid_o), 64'd0);
    check("mid_busy", 64'(busy_o), 64'd0);
    check("mid_done", 64'(done_o), 64'd0);
    check("mid_en_c", 64'(ram_en_c_o), 64'd0);
    check("mid_en_v", 64'(ram_en_v_o), 64'd0);
    check("mid_addr_c", 64'(ram_addr_c_o), 64'd0);
    check("mid_out_addr", 64'(out_addr_o), 64'd0);
    check("mid_out_data", 64'(out_data_o), 64'd0);
    check("mid_last", 64'(out_last_o), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    check("mid_held_valid", 64'(out_valid_o), 64'd0);
    rst = 1'b1;
    run_unload(1, 0, 18, 1'b0, "rst_restart");

    run_unload(1, 2, 18, 1'b0, "restart_ign");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
